// File: rtl/ram_sp_240x32_arb.sv
// Round-robin arbiter/sequencer sharing one single-port 240x32 SRAM
// between two clients, with lock ownership and an address range guard.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   req/wr/adr/dat/lck{0,1}_i  client request, direction, address,
//                              write data, keep-ownership
//   gnt{0,1}_o                 combinational grant (request consumed)
//   val{0,1}_o                 read data valid on rd_dat_o
//   rd_dat_o                   shared read data return
//   err_o                      pulse after an illegal address is consumed
//   ram_*                      SRAM address, enables, write/read data
module ram_sp_240x32_arb #(
    parameter int ADR_WD = 8,
    parameter int DAT_WD = 32,
    parameter int DEPTH  = 240
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              wr0_i,
    input  logic              wr1_i,
    input  logic [ADR_WD-1:0] adr0_i,
    input  logic [ADR_WD-1:0] adr1_i,
    input  logic [DAT_WD-1:0] dat0_i,
    input  logic [DAT_WD-1:0] dat1_i,
    input  logic              lck0_i,
    input  logic              lck1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              val0_o,
    output logic              val1_o,
    output logic [DAT_WD-1:0] rd_dat_o,
    output logic              err_o,
    output logic [ADR_WD-1:0] ram_adr_o,
    output logic              ram_wr_ena_o,
    output logic [DAT_WD-1:0] ram_wr_dat_o,
    output logic              ram_rd_ena_o,
    input  logic [DAT_WD-1:0] ram_rd_dat_i
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [ADR_WD:0] LIMIT = (ADR_WD+1)'(DEPTH);

    state_t            state_q, state_d;
    logic              pref_q;   // 1: client 1 wins a tie
    logic              any_gnt;
    logic              win_wr;
    logic              legal;
    logic [ADR_WD-1:0] win_adr, adr_q;
    logic [DAT_WD-1:0] win_dat, dat_q;
    logic              val0_q, val1_q, err_q;
    logic [DAT_WD-1:0] hold_q;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pref_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            val0_q  <= 1'b0;
            val1_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (gnt0_o)      pref_q <= 1'b1;
            else if (gnt1_o) pref_q <= 1'b0;
            if (any_gnt) begin
                adr_q <= win_adr;
                dat_q <= win_dat;
            end
            val0_q <= gnt0_o & ~wr0_i;
            val1_q <= gnt1_o & ~wr1_i;
            err_q  <= any_gnt & ~legal;
            hold_q <= rd_dat_o;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0_o && lck0_i)      state_d = OWN0;
                else if (gnt1_o && lck1_i) state_d = OWN1;
            end
            OWN0: if (!req0_i || !lck0_i) state_d = IDLE;
            OWN1: if (!req1_i || !lck1_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant and SRAM port outputs; grants are masked while in reset
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (rstn) begin
            unique case (state_q)
                IDLE: begin
                    if (req0_i && req1_i) begin
                        gnt0_o = ~pref_q;
                        gnt1_o = pref_q;
                    end else begin
                        gnt0_o = req0_i;
                        gnt1_o = req1_i;
                    end
                end
                OWN0:    gnt0_o = req0_i;
                OWN1:    gnt1_o = req1_i;
                default: ;
            endcase
        end
        any_gnt = gnt0_o | gnt1_o;
        win_adr = gnt1_o ? adr1_i : adr0_i;
        win_dat = gnt1_o ? dat1_i : dat0_i;
        win_wr  = gnt1_o ? wr1_i  : wr0_i;
        legal   = {1'b0, win_adr} < LIMIT;

        ram_adr_o    = any_gnt ? win_adr : adr_q;
        ram_wr_dat_o = any_gnt ? win_dat : dat_q;
        ram_wr_ena_o = any_gnt & legal & win_wr;
        ram_rd_ena_o = any_gnt & legal & ~win_wr;

        val0_o = val0_q;
        val1_o = val1_q;
        err_o  = err_q;
        // An illegal read still returns a strobe, but with zero data
        if (val0_q || val1_q) rd_dat_o = err_q ? '0 : ram_rd_dat_i;
        else                  rd_dat_o = hold_q;
    end

endmodule
